mac_pipe_array: RTL and testbench
=================================

Name: mac_pipe_array

Overview:
- Parametrised, pipelined, multi-lane unsigned MAC. It is the next generation of the single-lane PE multiply-accumulate.
- Each lane computes either a partial-sum MAC (a*w + sum_in) or a local running accumulation closed by a "last" marker.
- Results saturate instead of wrapping.
- Sits inside the PE datapath between the scratchpad readers and the psum forwarding path, with valid/ready flow control on both sides.

Parameters:
- LANES, 4: number of independent MAC lanes sharing one handshake.
- IN_BITWIDTH, 16: width of each activation and weight operand (unsigned).
- OUT_BITWIDTH, 32: width of each psum input, accumulator and result (unsigned). Must be >= IN_BITWIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- mode  in  1  per beat: 0 = PSUM (a*w+sum_in), 1 = ACC (local accumulate).
- in_last  in  1  per beat, ACC mode only: final beat of the accumulation; ignored in PSUM mode.
- a_in  in  LANES*IN_BITWIDTH  activations; lane i is at [i*IN_BITWIDTH +: IN_BITWIDTH].
- w_in  in  LANES*IN_BITWIDTH  weights, same packing as a_in.
- sum_in  in  LANES*OUT_BITWIDTH  incoming partial sums, used in PSUM mode only.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out  out  LANES*OUT_BITWIDTH  results, same packing as sum_in.
- out_sat  out  LANES  per lane: this result, or any step of the accumulation producing it, saturated.

Behaviour:
- Reset (async, rst=1): all pipeline valids = 0, out = 0, out_sat = 0, accumulators = 0, sticky sat flags = 0, out_valid = 0.
- in_ready may still be asserted during reset; no beat is captured while rst=1.
- Two-stage pipeline:
  - S1 registers the full 2*IN_BITWIDTH product per lane, plus mode, last and sum_in.
  - S2 performs the add and holds the output register.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. Every stage register updates only when adv = 1.
- A beat is accepted when in_valid && in_ready.
- Latency: the PSUM result is visible on out_valid 2 cycles after acceptance, with no stall.
- Throughput: 1 beat/cycle while out_ready stays high.
- Product clamp: if the product is >= 2^OUT_BITWIDTH, it is clamped to 2^OUT_BITWIDTH-1 and counts as saturation. This cannot occur with the defaults.
- PSUM beat in S2:
  - out = sat(product + sum_in); out_sat = the saturation of this beat; out_valid = 1.
  - The accumulators are untouched.
- ACC beat, in_last=0, in S2:
  - acc = sat(acc + product); sticky_sat |= the saturation of this step.
  - out_valid is not raised by this beat.
- ACC beat, in_last=1, in S2:
  - out = sat(acc + product); out_sat = sticky_sat | this step's saturation; out_valid = 1.
  - acc and sticky_sat are cleared to 0 in the same cycle.
- Sum width: the add uses OUT_BITWIDTH+1 bits. If the MSB is set, the result is 2^OUT_BITWIDTH-1.
- Interleaving: PSUM beats may arrive between ACC beats. They do not disturb an open accumulation.
- Stall: while out_valid && !out_ready, out, out_sat and all stage contents hold stable, and in_ready = 0.
- An S2 ACC non-last beat that completes while out_valid=0 simply updates acc, and out_valid remains 0.
- Reset mid-accumulation discards the partial acc with no output.
- Unused in_last on a PSUM beat has no effect.

Decomposition:
- Package mac_pkg:
  - typedef mode_e {MODE_PSUM=1'b0, MODE_ACC=1'b1}.
  - function sat_add(a, b, width) returning {sat, sum}.
- Sub-module mac_lane: one lane's S1 product register, S2 accumulator, sticky flag and saturating adder.
  - Takes adv and the beat controls from the parent.
  - The top level generates LANES instances and owns the shared valid/ready logic.

Test Plan:
1. PSUM, lane0 a=3, w=4, sum_in=10, out_ready=1 -> two cycles later out_valid=1, lane0 out=22, out_sat=0. Back-to-back beats give 1 result/cycle.
2. ACC, lane1 beats (a,w) = (2,5), (3,3), (1,7 with last) -> a single out_valid pulse, lane1 out=26. A following ACC sequence (1,1 last) gives 1, proving the clear.
3. Saturation: PSUM a=w=16'hFFFF, sum_in=32'hFFFF_FFFF -> out=32'hFFFF_FFFF, out_sat=1. In ACC mode, a mid-sequence overflow sets out_sat on the final result even if the last step does not overflow.
4. Backpressure: hold out_ready=0 with 3 PSUM beats offered -> in_ready drops after the pipeline fills, out stays stable, and release yields results in order with no loss or duplication.
5. Interleave: ACC (2,2), then PSUM (1,1,sum_in=5), then ACC (3,3,last) -> outputs 6 and then 13 in order.
6. Async reset asserted mid-accumulation and between clock edges -> out_valid=0 and out=0 immediately. A new ACC (4,4,last) then yields 16.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and the saturating adder for the multi-lane MAC array.
package mac_pkg;

  typedef enum logic {
    MODE_PSUM = 1'b0,
    MODE_ACC  = 1'b1
  } mode_e;

  // Widest result the saturating adder supports.
  localparam int SAT_MAX_W = 64;

  // Adds two unsigned values with one guard bit and clamps to 2^width-1.
  // Returns {sat, sum}; sum bits above width are always zero.
  function automatic logic [SAT_MAX_W:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int unsigned          width
  );
    logic [SAT_MAX_W:0] w_one;
    logic [SAT_MAX_W:0] w_lim;
    logic [SAT_MAX_W:0] w_full;
    w_one  = {{SAT_MAX_W{1'b0}}, 1'b1};
    w_lim  = (w_one << width) - w_one;
    w_full = {1'b0, a} + {1'b0, b};
    if (w_full > w_lim) begin
      sat_add = {1'b1, w_lim[SAT_MAX_W-1:0]};
    end else begin
      sat_add = {1'b0, w_full[SAT_MAX_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/mac_pipe_array_lane.sv
// One MAC lane: S1 product register, S2 accumulator, sticky flag and output.
module mac_lane
  import mac_pkg::*;
#(
  parameter int IN_BITWIDTH  = 16,
  parameter int OUT_BITWIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_adv,
  input  logic                    i_s1_valid,
  input  mode_e                   i_s1_mode,
  input  logic                    i_s1_last,
  input  logic [IN_BITWIDTH-1:0]  i_a,
  input  logic [IN_BITWIDTH-1:0]  i_w,
  input  logic [OUT_BITWIDTH-1:0] i_sum,
  output logic [OUT_BITWIDTH-1:0] o_out,
  output logic                    o_sat
);

  localparam int PW = 2 * IN_BITWIDTH;
  localparam int EW = (PW > OUT_BITWIDTH) ? PW : OUT_BITWIDTH;
  localparam logic [EW-1:0] L_MAX_EXT = EW'({OUT_BITWIDTH{1'b1}});

  logic [PW-1:0]           r_prod;
  logic [OUT_BITWIDTH-1:0] r_sum;
  logic [OUT_BITWIDTH-1:0] r_acc;
  logic                    r_sticky;
  logic [OUT_BITWIDTH-1:0] r_out;
  logic                    r_out_sat;

  logic [EW-1:0]           w_prod_ext;
  logic                    w_prod_sat;
  logic [OUT_BITWIDTH-1:0] w_prod_c;
  logic [OUT_BITWIDTH-1:0] w_base;
  logic [SAT_MAX_W:0]      w_add;
  logic [OUT_BITWIDTH-1:0] w_step_sum;
  logic                    w_step_sat;

  // Clamp the product, pick the addend (psum or accumulator) and do the saturating add.
  always_comb begin
    w_prod_ext = EW'(r_prod);
    w_prod_sat = (w_prod_ext > L_MAX_EXT);
    w_prod_c   = w_prod_sat ? {OUT_BITWIDTH{1'b1}} : w_prod_ext[OUT_BITWIDTH-1:0];
    w_base     = (i_s1_mode == MODE_PSUM) ? r_sum : r_acc;
    w_add      = sat_add(SAT_MAX_W'(w_prod_c), SAT_MAX_W'(w_base), OUT_BITWIDTH);
    w_step_sum = w_add[OUT_BITWIDTH-1:0];
    // Bits above OUT_BITWIDTH are zero after clamping; folding them in keeps the whole result consumed.
    w_step_sat = w_add[SAT_MAX_W] | (|w_add[SAT_MAX_W-1:OUT_BITWIDTH]) | w_prod_sat;
  end

  // Pipeline registers: S1 captures product/psum, S2 updates accumulator or output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod    <= '0;
      r_sum     <= '0;
      r_acc     <= '0;
      r_sticky  <= 1'b0;
      r_out     <= '0;
      r_out_sat <= 1'b0;
    end else if (i_adv) begin
      r_prod <= PW'(i_a) * PW'(i_w);
      r_sum  <= i_sum;
      if (i_s1_valid) begin
        if (i_s1_mode == MODE_PSUM) begin
          r_out     <= w_step_sum;
          r_out_sat <= w_step_sat;
        end else if (i_s1_last) begin
          r_out     <= w_step_sum;
          r_out_sat <= r_sticky | w_step_sat;
          r_acc     <= '0;
          r_sticky  <= 1'b0;
        end else begin
          r_acc    <= w_step_sum;
          r_sticky <= r_sticky | w_step_sat;
        end
      end
    end
  end

  assign o_out = r_out;
  assign o_sat = r_out_sat;

endmodule

// File: rtl/mac_pipe_array.sv
// Multi-lane two-stage saturating MAC with a single shared valid/ready handshake.
module mac_pipe_array
  import mac_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int IN_BITWIDTH  = 16,
  parameter int OUT_BITWIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode,
  input  logic                          in_last,
  input  logic [LANES*IN_BITWIDTH-1:0]  a_in,
  input  logic [LANES*IN_BITWIDTH-1:0]  w_in,
  input  logic [LANES*OUT_BITWIDTH-1:0] sum_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*OUT_BITWIDTH-1:0] out,
  output logic [LANES-1:0]              out_sat
);

  logic  w_adv;
  logic  r_s1_valid;
  mode_e r_s1_mode;
  logic  r_s1_last;
  logic  r_out_valid;

  // The whole pipeline moves together: it advances unless a result is waiting downstream.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  // Shared beat controls for S1 and result-valid for S2; ACC non-last beats produce no result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= MODE_PSUM;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_s1_mode   <= mode_e'(mode);
      r_s1_last   <= in_last;
      r_out_valid <= r_s1_valid && ((r_s1_mode == MODE_PSUM) || r_s1_last);
    end
  end

  assign out_valid = r_out_valid;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane #(
      .IN_BITWIDTH (IN_BITWIDTH),
      .OUT_BITWIDTH(OUT_BITWIDTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_adv     (w_adv),
      .i_s1_valid(r_s1_valid),
      .i_s1_mode (r_s1_mode),
      .i_s1_last (r_s1_last),
      .i_a       (a_in[g*IN_BITWIDTH +: IN_BITWIDTH]),
      .i_w       (w_in[g*IN_BITWIDTH +: IN_BITWIDTH]),
      .i_sum     (sum_in[g*OUT_BITWIDTH +: OUT_BITWIDTH]),
      .o_out     (out[g*OUT_BITWIDTH +: OUT_BITWIDTH]),
      .o_sat     (out_sat[g])
    );
  end

endmodule

// File: tb/tb_mac_pipe_array.sv
// Scoreboard bench for mac_pipe_array with an arithmetic reference model.
module tb_mac_pipe_array;

  localparam int L  = 4;
  localparam int IW = 16;
  localparam int OW = 32;
  localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              mode;
  logic              in_last;
  logic [L*IW-1:0]   a_in;
  logic [L*IW-1:0]   w_in;
  logic [L*OW-1:0]   sum_in;
  logic              out_valid;
  logic              out_ready;
  logic [L*OW-1:0]   out;
  logic [L-1:0]      out_sat;

  mac_pipe_array #(.LANES(L), .IN_BITWIDTH(IW), .OUT_BITWIDTH(OW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .in_last(in_last), .a_in(a_in), .w_in(w_in), .sum_in(sum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [L*OW-1:0] out;
    logic [L-1:0]    sat;
  } exp_t;

  exp_t            sb_q[$];
  longint unsigned m_acc[L];
  bit              m_sticky[L];
  int              n_vectors = 0;
  int              n_miscompares = 0;
  bit              rnd_done = 1'b0;

  // Reference model: computes each lane from the rules with 64-bit arithmetic.
  task automatic model_beat(input bit md, input bit lst, input logic [L*IW-1:0] a,
                            input logic [L*IW-1:0] w, input logic [L*OW-1:0] s);
    exp_t e;
    e.out = '0;
    e.sat = '0;
    for (int i = 0; i < L; i++) begin
      longint unsigned p, base, tot, res;
      bit sat;
      p   = longint'(a[i*IW +: IW]) * longint'(w[i*IW +: IW]);
      sat = 1'b0;
      if (p > MAXV) begin p = MAXV; sat = 1'b1; end
      base = md ? m_acc[i] : longint'(s[i*OW +: OW]);
      tot  = p + base;
      if (tot > MAXV) sat = 1'b1;
      res  = sat ? MAXV : tot;
      if (!md) begin
        e.out[i*OW +: OW] = res[OW-1:0];
        e.sat[i] = sat;
      end else if (lst) begin
        e.out[i*OW +: OW] = res[OW-1:0];
        e.sat[i] = m_sticky[i] | sat;
        m_acc[i] = 0;
        m_sticky[i] = 1'b0;
      end else begin
        m_acc[i] = res;
        m_sticky[i] = m_sticky[i] | sat;
      end
    end
    if (!md || lst) sb_q.push_back(e);
  endtask

  task automatic model_clear();
    sb_q.delete();
    for (int i = 0; i < L; i++) begin
      m_acc[i] = 0;
      m_sticky[i] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vectors++;
    if (act !== req) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Offer one beat; returns #1 after the edge that accepted it.
  task automatic send(input bit md, input bit lst, input logic [L*IW-1:0] a,
                      input logic [L*IW-1:0] w, input logic [L*OW-1:0] s);
    bit acc;
    in_valid = 1'b1; mode = md; in_last = lst; a_in = a; w_in = w; sum_in = s;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        model_beat(md, lst, a, w, s);
        return;
      end
    end
    check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic stop();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for the next result and check one lane against a constant.
  task automatic wait_result(input int lane, input logic [31:0] v, input bit s, input string name);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        check({name, "_val"}, 64'(out[lane*OW +: OW]), 64'(v));
        check({name, "_sat"}, 64'(out_sat[lane]), 64'(s));
        return;
      end
    end
    check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  function automatic logic [L*IW-1:0] lane_in(input int lane, input logic [15:0] v);
    logic [L*IW-1:0] r;
    r = '0;
    r[lane*IW +: IW] = v;
    return r;
  endfunction

  function automatic logic [L*OW-1:0] lane_sum(input int lane, input logic [31:0] v);
    logic [L*OW-1:0] r;
    r = '0;
    r[lane*OW +: OW] = v;
    return r;
  endfunction

  function automatic logic [L*IW-1:0] rnd_in();
    logic [L*IW-1:0] r;
    for (int i = 0; i < L; i++) r[i*IW +: IW] = 16'($urandom);
    return r;
  endfunction

  function automatic logic [L*OW-1:0] rnd_sum();
    logic [L*OW-1:0] r;
    for (int i = 0; i < L; i++) r[i*OW +: OW] = $urandom;
    return r;
  endfunction

  // Monitor: pops the scoreboard on every accepted result and checks stall behaviour.
  initial begin : monitor
    exp_t            e;
    logic [L*OW-1:0] prev_out;
    logic [L-1:0]    prev_sat;
    bit              have_prev;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_prev = 1'b0;
      end else if (out_valid) begin
        if (have_prev) begin
          check("stall_hold_out", 64'(out != prev_out), 64'd0);
          check("stall_hold_sat", 64'(out_sat), 64'(prev_sat));
        end
        if (out_ready) begin
          have_prev = 1'b0;
          if (sb_q.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("result_out_lo", out[63:0], e.out[63:0]);
            check("result_out_hi", out[127:64], e.out[127:64]);
            check("result_sat", 64'(out_sat), 64'(e.sat));
          end
        end else begin
          check("stall_in_ready", 64'(in_ready), 64'd0);
          prev_out = out;
          prev_sat = out_sat;
          have_prev = 1'b1;
        end
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin : main
    time t0;
    rst = 1'b0; in_valid = 1'b0; mode = 1'b0; in_last = 1'b0;
    a_in = '0; w_in = '0; sum_in = '0; out_ready = 1'b1;
    model_clear();
    #1 rst = 1'b1;
    #11;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(|out), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic PSUM with 2-cycle latency, then back-to-back throughput.
    send(1'b0, 1'b1, lane_in(0, 16'd3), lane_in(0, 16'd4), lane_sum(0, 32'd10));
    stop();
    @(negedge clk);
    check("lat_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("psum_basic", 64'(out[31:0]), 64'd22);
    check("psum_basic_sat", 64'(out_sat[0]), 64'd0);
    @(posedge clk); #1;
    t0 = $time;
    for (int k = 0; k < 4; k++) send(1'b0, 1'b0, rnd_in(), rnd_in(), rnd_sum());
    stop();
    check("throughput_cycles", 64'(($time - t0) / 10), 64'd4);
    repeat (4) @(posedge clk); #1;

    // 2: accumulation on lane 1, then a one-beat accumulation proving the clear.
    send(1'b1, 1'b0, lane_in(1, 16'd2), lane_in(1, 16'd5), '0);
    send(1'b1, 1'b0, lane_in(1, 16'd3), lane_in(1, 16'd3), '0);
    send(1'b1, 1'b1, lane_in(1, 16'd1), lane_in(1, 16'd7), '0);
    stop();
    wait_result(1, 32'd26, 1'b0, "acc_seq");
    @(posedge clk); #1;
    send(1'b1, 1'b1, lane_in(1, 16'd1), lane_in(1, 16'd1), '0);
    stop();
    wait_result(1, 32'd1, 1'b0, "acc_clear");
    @(posedge clk); #1;

    // 3: PSUM saturation on all lanes; ACC mid-sequence overflow is sticky.
    send(1'b0, 1'b0, {L{16'hFFFF}}, {L{16'hFFFF}}, {L{32'hFFFF_FFFF}});
    stop();
    wait_result(0, 32'hFFFF_FFFF, 1'b1, "psum_sat");
    @(posedge clk); #1;
    send(1'b1, 1'b0, lane_in(0, 16'hFFFF), lane_in(0, 16'hFFFF), '0);
    send(1'b1, 1'b0, lane_in(0, 16'hFFFF), lane_in(0, 16'hFFFF), '0);
    send(1'b1, 1'b1, lane_in(0, 16'd0), lane_in(0, 16'd0), '0);
    stop();
    wait_result(0, 32'hFFFF_FFFF, 1'b1, "acc_sticky_sat");
    @(posedge clk); #1;

    // 4: backpressure with three PSUM beats offered.
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) send(1'b0, 1'b0, rnd_in(), rnd_in(), rnd_sum());
        stop();
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // 5: PSUM interleaved inside an open accumulation on lane 2.
    send(1'b1, 1'b0, lane_in(2, 16'd2), lane_in(2, 16'd2), '0);
    send(1'b0, 1'b0, lane_in(2, 16'd1), lane_in(2, 16'd1), lane_sum(2, 32'd5));
    send(1'b1, 1'b1, lane_in(2, 16'd3), lane_in(2, 16'd3), '0);
    stop();
    wait_result(2, 32'd6, 1'b0, "interleave_psum");
    wait_result(2, 32'd13, 1'b0, "interleave_acc");
    @(posedge clk); #1;

    // 6: async reset between edges while a result is showing and an accumulation is open.
    send(1'b1, 1'b0, lane_in(3, 16'd5), lane_in(3, 16'd5), '0);
    send(1'b0, 1'b0, lane_in(3, 16'd7), lane_in(3, 16'd7), lane_sum(3, 32'd1));
    stop();
    @(posedge clk); #3;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    model_clear();
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_out", 64'(|out), 64'd0);
    @(negedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    send(1'b1, 1'b1, lane_in(3, 16'd4), lane_in(3, 16'd4), '0);
    stop();
    wait_result(3, 32'd16, 1'b0, "after_rst");
    @(posedge clk); #1;

    // Random traffic with random backpressure.
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          send(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), rnd_in(), rnd_in(), rnd_sum());
          if ($urandom_range(0, 3) == 0) begin
            stop();
            @(posedge clk); #1;
          end
        end
        stop();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    for (int c = 0; c < 50 && sb_q.size() != 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
